buzz_pattern_gen: RTL and testbench

Parametrised buzzer driver for the clock's alarm and key-beep paths. It produces a square-wave tone with a run-time programmable half-period. The tone plays continuously or as a counted on/off beep pattern, under start/stop control with busy and done status. It sits between the alarm/keypad control logic and the buzzer pin, and replaces the fixed-divide toggle generator.

---
 rtl/buzz_pattern_gen_pkg.sv | 18 +
 rtl/buzz_tick_counter.sv | 25 ++
 rtl/buzz_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_buzz_pattern_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/buzz_pattern_gen_pkg.sv
// Shared encodings and default widths for the buzzer pattern generator.
package buzz_pkg;

    localparam int DEF_W  = 16;
    localparam int DEF_LW = 8;
    localparam int DEF_RW = 8;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_CONT = 2'd1;
    localparam logic [1:0] MODE_BEEP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/buzz_tick_counter.sv
// Half-period timer: counts clk cycles and pulses wrap on the last cycle of each half-period.
module buzz_tick_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] half_period,
    output logic         wrap
);

    logic [W-1:0] count;

    assign wrap = en && !clr && (count == half_period - W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/buzz_pattern_gen.sv
// Buzzer driver: programmable square-wave tone, continuous or as a counted beep pattern.
module buzz_pattern_gen
    import buzz_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int LW = DEF_LW,
    parameter int RW = DEF_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  half_period,
    input  logic [LW-1:0] on_len,
    input  logic [LW-1:0] off_len,
    input  logic [RW-1:0] reps,
    output logic          buzz,
    output logic          busy,
    output logic          done
);

    state_t        state;
    logic [1:0]    mode_q;
    logic [W-1:0]  hp_q;
    logic [LW-1:0] on_q;
    logic [LW-1:0] off_q;
    logic [RW-1:0] reps_q;
    logic [LW-1:0] half_cnt;
    logic [RW-1:0] rep_cnt;
    logic          buzz_q;
    logic          busy_q;
    logic          done_q;

    logic          wrap;
    logic          tick_clr;
    logic          tick_en;
    logic          start_ok;
    logic [LW-1:0] half_nxt;
    logic [RW-1:0] rep_nxt;

    assign start_ok = start && !stop && (state == ST_IDLE) &&
                      ((mode == MODE_CONT) || (mode == MODE_BEEP));
    assign tick_en  = (state != ST_IDLE);
    assign tick_clr = stop || (state == ST_IDLE);
    assign half_nxt = half_cnt + LW'(1);
    assign rep_nxt  = rep_cnt + RW'(1);

    buzz_tick_counter #(.W(W)) u_tick (
        .clk         (clk),
        .rst         (rst),
        .clr         (tick_clr),
        .en          (tick_en),
        .half_period (hp_q),
        .wrap        (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_OFF;
            hp_q     <= '0;
            on_q     <= '0;
            off_q    <= '0;
            reps_q   <= '0;
            half_cnt <= '0;
            rep_cnt  <= '0;
            buzz_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state    <= ST_IDLE;
                half_cnt <= '0;
                buzz_q   <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            // zero lengths would never wrap; run them as one unit
                            mode_q   <= mode;
                            hp_q     <= (half_period == '0) ? W'(1)  : half_period;
                            on_q     <= (on_len == '0)      ? LW'(1) : on_len;
                            off_q    <= (off_len == '0)     ? LW'(1) : off_len;
                            reps_q   <= reps;
                            half_cnt <= '0;
                            rep_cnt  <= '0;
                            state    <= ST_ON;
                            buzz_q   <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    ST_ON: begin
                        if (wrap) begin
                            if ((mode_q == MODE_BEEP) && (half_nxt == on_q)) begin
                                state    <= ST_GAP;
                                half_cnt <= '0;
                                buzz_q   <= 1'b0;
                            end else begin
                                half_cnt <= half_nxt;
                                buzz_q   <= ~buzz_q;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (wrap) begin
                            if (half_nxt == off_q) begin
                                half_cnt <= '0;
                                rep_cnt  <= rep_nxt;
                                // reps of zero never matches, so the pattern repeats until stop
                                if ((reps_q != '0) && (rep_nxt == reps_q)) begin
                                    state  <= ST_IDLE;
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end else begin
                                    state  <= ST_ON;
                                    buzz_q <= 1'b1;
                                end
                            end else begin
                                half_cnt <= half_nxt;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        buzz_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign buzz = buzz_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_buzz_pattern_gen.sv
// Directed bench for buzz_pattern_gen: per-cycle vector table plus hand-written corner sequences.
module tb_buzz_pattern_gen;

    localparam int W  = 16;
    localparam int LW = 8;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [W-1:0]  half_period = '0;
    logic [LW-1:0] on_len = '0;
    logic [LW-1:0] off_len = '0;
    logic [RW-1:0] reps = '0;
    logic          buzz;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    buzz_pattern_gen #(.W(W), .LW(LW), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .half_period (half_period),
        .on_len      (on_len),
        .off_len     (off_len),
        .reps        (reps),
        .buzz        (buzz),
        .busy        (busy),
        .done        (done)
    );

    // one record = inputs presented before an edge, {buzz,busy,done} expected after it
    typedef struct {
        string         name;
        logic          r;
        logic          s;
        logic          p;
        logic [1:0]    m;
        logic [W-1:0]  hp;
        logic [LW-1:0] on;
        logic [LW-1:0] off;
        logic [RW-1:0] rp;
        logic [2:0]    exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic r, input logic s, input logic p,
                       input logic [1:0] m, input int hp, input int on, input int off,
                       input int rp, input logic [2:0] exp);
        vec_t v;
        v.name = name; v.r = r; v.s = s; v.p = p; v.m = m;
        v.hp = W'(hp); v.on = LW'(on); v.off = LW'(off); v.rp = RW'(rp);
        v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic idle(input string name, input logic [2:0] exp);
        add(name, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0, exp);
    endtask

    task automatic drive(input logic r, input logic s, input logic p, input logic [1:0] m,
                         input int hp, input int on, input int off, input int rp);
        rst = r; start = s; stop = p; mode = m;
        half_period = W'(hp); on_len = LW'(on); off_len = LW'(off); reps = RW'(rp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] exp);
        total++;
        if ({buzz, busy, done} !== exp) begin
            bad++;
            $display("FAIL %s: buzz/busy/done=%b expected %b", name, {buzz, busy, done}, exp);
        end
    endtask

    initial begin
        // reset, including a start held during reset
        add("reset", 1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0, 3'b000);
        add("reset_with_start", 1'b1, 1'b1, 1'b0, 2'd2, 4, 2, 2, 2, 3'b000);
        idle("idle_after_reset", 3'b000);

        // BEEP hp=4 on=2 off=2 reps=2: high t+1..4, t+17..20; done at t+33
        add("beep_c1", 1'b0, 1'b1, 1'b0, 2'd2, 4, 2, 2, 2, 3'b110);
        for (int k = 2; k <= 34; k++) begin
            logic b;
            b = (k <= 4) || (k >= 17 && k <= 20);
            idle($sformatf("beep_c%0d", k), {b, (k <= 32), (k == 33)});
        end

        // degenerate zero config behaves as all ones
        add("degen_c1", 1'b0, 1'b1, 1'b0, 2'd2, 0, 0, 0, 1, 3'b110);
        idle("degen_c2", 3'b010);
        idle("degen_c3", 3'b001);
        idle("degen_c4", 3'b000);

        // arbitration and ignored modes
        add("start_stop_same", 1'b0, 1'b1, 1'b1, 2'd1, 3, 1, 1, 1, 3'b000);
        idle("start_stop_after", 3'b000);
        add("start_mode_off", 1'b0, 1'b1, 1'b0, 2'd0, 3, 1, 1, 1, 3'b000);
        add("start_mode_rsvd", 1'b0, 1'b1, 1'b0, 2'd3, 3, 1, 1, 1, 3'b000);
        idle("mode_ignored_after", 3'b000);

        // CONT hp=3 with an ignored restart (hp=7) at cycle 5, then stop
        add("cont_c1", 1'b0, 1'b1, 1'b0, 2'd1, 3, 0, 0, 0, 3'b110);
        for (int k = 2; k <= 12; k++) begin
            logic b;
            b = (((k - 1) / 3) % 2) == 0;
            if (k == 5) add("cont_c5_restart", 1'b0, 1'b1, 1'b0, 2'd2, 7, 1, 1, 1, {b, 2'b10});
            else        idle($sformatf("cont_c%0d", k), {b, 2'b10});
        end
        add("cont_stop", 1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 3'b000);
        idle("cont_after_stop1", 3'b000);
        idle("cont_after_stop2", 3'b000);

        // back-to-back: new start accepted during the done cycle
        add("b2b_a1", 1'b0, 1'b1, 1'b0, 2'd2, 1, 1, 1, 1, 3'b110);
        idle("b2b_a2", 3'b010);
        idle("b2b_a_done", 3'b001);
        add("b2b_b1", 1'b0, 1'b1, 1'b0, 2'd2, 2, 1, 1, 1, 3'b110);
        idle("b2b_b2", 3'b110);
        idle("b2b_b3", 3'b010);
        idle("b2b_b4", 3'b010);
        idle("b2b_b_done", 3'b001);
        idle("b2b_b_end", 3'b000);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].m, int'(tbl[i].hp), int'(tbl[i].on),
                  int'(tbl[i].off), int'(tbl[i].rp));
            tick();
            check(tbl[i].name, tbl[i].exp);
        end

        // reset during ON aborts with no done, later start is normal
        drive(1'b0, 1'b1, 1'b0, 2'd2, 4, 2, 2, 2);
        tick(); check("rstmid_c1", 3'b110);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0);
        tick(); check("rstmid_c2", 3'b110);
        rst = 1'b1;
        tick(); check("rstmid_reset", 3'b000);
        rst = 1'b0;
        tick(); check("rstmid_idle", 3'b000);
        drive(1'b0, 1'b1, 1'b0, 2'd2, 1, 1, 1, 1);
        tick(); check("rstmid_new_c1", 3'b110);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0);
        tick(); check("rstmid_new_c2", 3'b010);
        tick(); check("rstmid_new_done", 3'b001);

        // infinite BEEP, 2-cycle bursts, run past 256 reps
        drive(1'b0, 1'b1, 1'b0, 2'd2, 1, 1, 1, 0);
        for (int k = 1; k <= 600; k++) begin
            tick();
            if (k == 1) drive(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0);
            check($sformatf("inf_c%0d", k), {(k % 2) == 1, 1'b1, 1'b0});
        end
        stop = 1'b1;
        tick(); check("inf_stop", 3'b000);
        stop = 1'b0;
        tick(); check("inf_after_stop", 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
